// File: rtl/v_pkg.sv
// Shared vector-unit definitions: reduction opcodes from the decoder, FSM states
// and default datapath widths.
package v_pkg;

  localparam int unsigned V_VLEN = 128;
  localparam int unsigned V_ELEN = 32;

  localparam logic [2:0] VRED_VREDSUM = 3'd1;
  localparam logic [2:0] VRED_VREDMAX = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } v_red_state_t;

endpackage

// File: rtl/v_red_alu.sv
// Single-element reduction step: wrapping add or signed max against the accumulator.
// Kept separate so the datapath can later become a tree without touching the FSM.
module v_red_alu
  import v_pkg::*;
#(
  parameter int unsigned ELEN = V_ELEN
) (
  input  logic [2:0]      op,
  input  logic [ELEN-1:0] acc,
  input  logic [ELEN-1:0] elem,
  input  logic            active,
  output logic [ELEN-1:0] next_acc
);

  always_comb begin
    next_acc = acc;
    if (active) begin
      if (op == VRED_VREDSUM) begin
        next_acc = acc + elem;
      end else if (op == VRED_VREDMAX) begin
        if ($signed(elem) > $signed(acc)) next_acc = elem;
      end
    end
  end

endmodule

// File: rtl/v_red_unit.sv
// Sequential vector reduction (vredsum / vredmax): one element per cycle, seeded
// from vs1[0], result presented with a one-cycle registered done pulse.
module v_red_unit
  import v_pkg::*;
#(
  parameter  int unsigned VLEN     = V_VLEN,
  parameter  int unsigned ELEN     = V_ELEN,
  localparam int unsigned NUM_ELEM = VLEN / ELEN,
  localparam int unsigned VlW      = $clog2(NUM_ELEM + 1)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic [2:0]          v_red_op,
  input  logic [VlW-1:0]      vl,
  input  logic                vm,
  input  logic [NUM_ELEM-1:0] v0_mask,
  input  logic [ELEN-1:0]     vs1_scalar,
  input  logic [VLEN-1:0]     vs2,
  output logic                busy,
  output logic                done,
  output logic [ELEN-1:0]     result
);

  localparam int unsigned IdxW = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

  v_red_state_t        state_q, state_d;
  logic [ELEN-1:0]     acc_q, acc_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [VlW-1:0]      vl_q, vl_d;
  logic [2:0]          op_q, op_d;
  logic                vm_q, vm_d;
  logic [NUM_ELEM-1:0] mask_q, mask_d;
  logic [VLEN-1:0]     vs2_q, vs2_d;
  logic [ELEN-1:0]     result_q, result_d;
  logic                done_q, done_d;

  logic [VlW-1:0]      vl_clamp;
  logic                op_ok;
  logic                last;
  logic [ELEN-1:0]     elem;
  logic                active;
  logic [ELEN-1:0]     next_acc;

  assign vl_clamp = (vl > VlW'(NUM_ELEM)) ? VlW'(NUM_ELEM) : vl;
  assign op_ok    = (v_red_op == VRED_VREDSUM) || (v_red_op == VRED_VREDMAX);
  // Only meaningful in ACCUM, where vl_q is known to be non-zero.
  assign last     = (VlW'(idx_q) == (vl_q - VlW'(1)));
  assign elem     = vs2_q[idx_q*ELEN +: ELEN];
  assign active   = vm_q | mask_q[idx_q];

  v_red_alu #(
    .ELEN(ELEN)
  ) u_alu (
    .op      (op_q),
    .acc     (acc_q),
    .elem    (elem),
    .active  (active),
    .next_acc(next_acc)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    vl_d     = vl_q;
    op_d     = op_q;
    vm_d     = vm_q;
    mask_d   = mask_q;
    vs2_d    = vs2_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && op_ok) begin
          op_d    = v_red_op;
          vm_d    = vm;
          mask_d  = v0_mask;
          vs2_d   = vs2;
          vl_d    = vl_clamp;
          acc_d   = vs1_scalar;
          idx_d   = '0;
          state_d = (vl_clamp == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        acc_d = next_acc;
        idx_d = idx_q + 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      vl_q     <= '0;
      op_q     <= '0;
      vm_q     <= 1'b0;
      mask_q   <= '0;
      vs2_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      vl_q     <= vl_d;
      op_q     <= op_d;
      vm_q     <= vm_d;
      mask_q   <= mask_d;
      vs2_q    <= vs2_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_v_red_unit.sv
// Directed bench for v_red_unit: sum/max, masking, vl clamp/zero, ignored starts
// and asynchronous reset mid-operation.
module tb_v_red_unit;

  logic         clk;
  logic         nrst;
  logic         start;
  logic [2:0]   v_red_op;
  logic [2:0]   vl;
  logic         vm;
  logic [3:0]   v0_mask;
  logic [31:0]  vs1_scalar;
  logic [127:0] vs2;
  logic         busy;
  logic         done;
  logic [31:0]  result;

  int n_checks = 0;
  int n_fail   = 0;

  v_red_unit dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .v_red_op  (v_red_op),
    .vl        (vl),
    .vm        (vm),
    .v0_mask   (v0_mask),
    .vs1_scalar(vs1_scalar),
    .vs2       (vs2),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Issue one reduction, scramble the inputs after acceptance, then check latency,
  // busy length, result and that done lasts exactly one cycle.
  task automatic run_red(input string tag, input logic [2:0] op, input logic [2:0] vl_in,
                         input logic vm_in, input logic [3:0] mask, input logic [31:0] s,
                         input logic [127:0] v, input logic [31:0] exp_res);
    int lat;
    int busy_cnt;
    int vlc;
    bit seen;
    vlc = (vl_in > 3'd4) ? 4 : int'(vl_in);
    @(negedge clk);
    start = 1'b1; v_red_op = op; vl = vl_in; vm = vm_in; v0_mask = mask;
    vs1_scalar = s; vs2 = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; v_red_op = 3'd1; vl = 3'd1; vm = ~vm_in; v0_mask = ~mask;
    vs1_scalar = ~s; vs2 = ~v;
    busy_cnt = 0; lat = 0; seen = 1'b0;
    for (int j = 0; j < 20 && !seen; j++) begin
      if (j > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        lat  = j;
      end
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_latency"}, 32'(lat), 32'(vlc + 1));
    check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(vlc + 1));
    check_eq({tag, "_result"}, result, exp_res);
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check_eq({tag, "_idle_after"}, 32'(busy), 32'd0);
    check_eq({tag, "_result_held"}, result, exp_res);
  endtask

  int pulses;
  logic [31:0] got;

  initial begin
    nrst = 1'b0; start = 1'b0; v_red_op = 3'd0; vl = 3'd0; vm = 1'b1; v0_mask = 4'd0;
    vs1_scalar = 32'd0; vs2 = 128'd0;
    #3;
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;

    run_red("sum_basic", 3'd1, 3'd4, 1'b1, 4'h0, 32'd10,
            {32'd4, 32'd3, 32'd2, 32'd1}, 32'd20);
    run_red("max_mixed", 3'd2, 3'd4, 1'b1, 4'h0, 32'hFFFF_FFFB,
            {32'hFFFF_FFFF, 32'd7, 32'hFFFF_FF9C, 32'd3}, 32'd7);
    run_red("max_signed", 3'd2, 3'd4, 1'b1, 4'h0, 32'hFFFF_FFFB,
            {4{32'hFFFF_FFF7}}, 32'hFFFF_FFFB);
    run_red("sum_mask0101", 3'd1, 3'd4, 1'b0, 4'b0101, 32'd0,
            {32'd8, 32'd4, 32'd2, 32'd1}, 32'd5);
    run_red("sum_mask_none", 3'd1, 3'd4, 1'b0, 4'b0000, 32'd0,
            {32'd8, 32'd4, 32'd2, 32'd1}, 32'd0);
    run_red("sum_vl0", 3'd1, 3'd0, 1'b1, 4'h0, 32'h1234,
            {32'd8, 32'd4, 32'd2, 32'd1}, 32'h1234);
    run_red("sum_clamp_wrap", 3'd1, 3'd7, 1'b1, 4'h0, 32'd0,
            {32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0}, 32'h8000_0000);
    run_red("max_vl2", 3'd2, 3'd2, 1'b1, 4'h0, 32'd0,
            {32'd100, 32'd90, 32'd5, 32'd3}, 32'd5);

    // Illegal opcodes must not start anything.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1; v_red_op = (k == 0) ? 3'd0 : 3'd3; vl = 3'd4; vm = 1'b1;
      vs1_scalar = 32'd99; vs2 = {4{32'd1}};
      @(negedge clk);
      start = 1'b0;
      pulses = 0;
      for (int j = 0; j < 8; j++) begin
        if (busy || done) pulses++;
        @(negedge clk);
      end
      check_eq(k == 0 ? "illegal_op0" : "illegal_op3", 32'(pulses), 32'd0);
    end
    check_eq("illegal_result_kept", result, 32'd5);

    // A start while busy must not disturb the running reduction.
    @(negedge clk);
    start = 1'b1; v_red_op = 3'd1; vl = 3'd4; vm = 1'b1; vs1_scalar = 32'd10;
    vs2 = {32'd4, 32'd3, 32'd2, 32'd1};
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; v_red_op = 3'd2; vl = 3'd2; vs1_scalar = 32'd500; vs2 = {4{32'd77}};
    pulses = 0; got = 32'd0;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        pulses++;
        got = result;
      end
    end
    check_eq("busy_start_pulses", 32'(pulses), 32'd1);
    check_eq("busy_start_result", got, 32'd20);

    // Asynchronous reset in the middle of ACCUM.
    @(negedge clk);
    start = 1'b1; v_red_op = 3'd1; vl = 3'd4; vm = 1'b1; vs1_scalar = 32'd100;
    vs2 = {4{32'd1}};
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("pre_reset_busy", 32'(busy), 32'd1);
    #2 nrst = 1'b0;
    #1;
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_done", 32'(done), 32'd0);
    check_eq("async_rst_result", result, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    pulses = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check_eq("post_rst_quiet", 32'(pulses), 32'd0);
    run_red("sum_after_rst", 3'd1, 3'd3, 1'b1, 4'h0, 32'd1,
            {32'd50, 32'd6, 32'd5, 32'd4}, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
